fu_alu_mul_pipe: RTL and testbench



---
 rtl/fu_alu_mul_pipe.sv | 128 ++++++++++++
 tb/tb_fu_alu_mul_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fu_alu_mul_pipe.sv
// Parametrised TTA ALU function unit with low-half multiply and a
// configurable trigger-to-result latency ending in a retiring result register.
module fu_alu_mul_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1,
    parameter int MUL_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] io_t1data,
    input  logic [3:0]        io_t1opcode,
    input  logic              io_t1load,
    input  logic [DATA_W-1:0] io_o1data,
    input  logic              io_o1load,
    output logic [DATA_W-1:0] io_r1data,
    input  logic              io_glock
);

    localparam int SH_W = $clog2(DATA_W);

    logic              w_trig;
    logic              w_o1_en;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [SH_W-1:0]   w_amt;
    logic [DATA_W-1:0] w_sxhw;
    logic [DATA_W-1:0] w_sxqw;
    logic [DATA_W-1:0] w_mul;
    logic [DATA_W-1:0] w_res;
    logic              w_ret_v;
    logic [DATA_W-1:0] w_ret_d;

    logic [DATA_W-1:0] r_o1;
    logic [DATA_W-1:0] r_r1;

    assign w_trig  = io_t1load & ~io_glock;
    assign w_o1_en = io_o1load & ~io_glock;
    assign w_a     = io_t1data;
    // A same-cycle operand write feeds the trigger directly
    assign w_b     = (w_o1_en && w_trig) ? io_o1data : r_o1;
    assign w_amt   = w_b[SH_W-1:0];

    generate
        if (DATA_W > 16) begin : g_sxhw
            assign w_sxhw = {{(DATA_W-16){w_a[15]}}, w_a[15:0]};
        end else begin : g_sxhw_id
            assign w_sxhw = w_a;
        end
        if (DATA_W > 8) begin : g_sxqw
            assign w_sxqw = {{(DATA_W-8){w_a[7]}}, w_a[7:0]};
        end else begin : g_sxqw_id
            assign w_sxqw = w_a;
        end
        if (MUL_EN != 0) begin : g_mul
            assign w_mul = w_a * w_b;
        end else begin : g_nomul
            assign w_mul = '0;
        end
    endgenerate

    always_comb begin
        w_res = '0;
        case (io_t1opcode)
            4'd0:    w_res = w_a + w_b;
            4'd1:    w_res = w_a & w_b;
            4'd2:    w_res = {{(DATA_W-1){1'b0}}, w_a == w_b};
            4'd3:    w_res = {{(DATA_W-1){1'b0}}, $signed(w_a) > $signed(w_b)};
            4'd4:    w_res = {{(DATA_W-1){1'b0}}, w_a > w_b};
            4'd5:    w_res = w_a | w_b;
            4'd6:    w_res = w_a << w_amt;
            4'd7:    w_res = DATA_W'($signed(w_a) >>> w_amt);
            4'd8:    w_res = w_a >> w_amt;
            4'd9:    w_res = w_a - w_b;
            4'd10:   w_res = w_sxhw;
            4'd11:   w_res = w_sxqw;
            4'd12:   w_res = w_a ^ w_b;
            4'd13:   w_res = w_mul;
            default: w_res = '0;
        endcase
    end

    // LATENCY-1 internal stages; the result register is the final stage
    generate
        if (LATENCY == 1) begin : g_l1
            assign w_ret_v = w_trig;
            assign w_ret_d = w_res;
        end else begin : g_pipe
            logic [LATENCY-2:0] r_v;
            logic [DATA_W-1:0]  r_d [LATENCY-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        r_d[i] <= '0;
                    end
                end else if (!io_glock) begin
                    r_v[0] <= w_trig;
                    r_d[0] <= w_res;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        r_v[i] <= r_v[i-1];
                        r_d[i] <= r_d[i-1];
                    end
                end
            end

            assign w_ret_v = r_v[LATENCY-2];
            assign w_ret_d = r_d[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_o1 <= '0;
            r_r1 <= '0;
        end else if (!io_glock) begin
            if (w_o1_en) begin
                r_o1 <= io_o1data;
            end
            if (w_ret_v) begin
                r_r1 <= w_ret_d;
            end
        end
    end

    assign io_r1data = r_r1;

endmodule

// File: tb/tb_fu_alu_mul_pipe.sv
// Bench for fu_alu_mul_pipe: four configurations driven in lockstep,
// results checked against a per-instance scoreboard of due edges.
module tb_fu_alu_mul_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        t1load = 1'b0;
    logic        o1load = 1'b0;
    logic        glock = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;

    logic [31:0] r32;
    logic [15:0] r16;
    logic [31:0] r3;
    logic [31:0] r0;

    always #5 clk = ~clk;

    fu_alu_mul_pipe #(.DATA_W(32), .LATENCY(1), .MUL_EN(1)) u32 (
        .clk(clk), .reset(reset), .io_t1data(a), .io_t1opcode(op),
        .io_t1load(t1load), .io_o1data(b), .io_o1load(o1load),
        .io_r1data(r32), .io_glock(glock));

    fu_alu_mul_pipe #(.DATA_W(16), .LATENCY(1), .MUL_EN(1)) u16 (
        .clk(clk), .reset(reset), .io_t1data(a[15:0]), .io_t1opcode(op),
        .io_t1load(t1load), .io_o1data(b[15:0]), .io_o1load(o1load),
        .io_r1data(r16), .io_glock(glock));

    fu_alu_mul_pipe #(.DATA_W(32), .LATENCY(3), .MUL_EN(1)) u3 (
        .clk(clk), .reset(reset), .io_t1data(a), .io_t1opcode(op),
        .io_t1load(t1load), .io_o1data(b), .io_o1load(o1load),
        .io_r1data(r3), .io_glock(glock));

    fu_alu_mul_pipe #(.DATA_W(32), .LATENCY(1), .MUL_EN(0)) u0 (
        .clk(clk), .reset(reset), .io_t1data(a), .io_t1opcode(op),
        .io_t1load(t1load), .io_o1data(b), .io_o1load(o1load),
        .io_r1data(r0), .io_glock(glock));

    typedef struct {
        int          due;
        logic [31:0] v;
    } sb_t;

    typedef struct {
        logic        t1;
        logic        o1;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e32;
        logic [15:0] e16;
    } vec_t;

    sb_t         sbq [4][$];
    logic [31:0] last [4];
    logic [31:0] act [4];
    string       nm [4];
    int          ucnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tv [$];

    always_comb begin
        act[0] = r32;
        act[1] = {16'd0, r16};
        act[2] = r3;
        act[3] = r0;
    end

    task automatic cmp(input string what, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h exp %h at %0t", what, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic rs;
        logic lk;
        logic [31:0] e;
        rs = reset;
        lk = glock;
        if (!lk) ucnt++;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (rs) begin
                sbq[k].delete();
                last[k] = 32'd0;
                cmp({nm[k], "_reset"}, act[k], 32'd0);
            end else if (!lk && sbq[k].size() > 0 && sbq[k][0].due == ucnt) begin
                e = sbq[k].pop_front().v;
                last[k] = e;
                cmp({nm[k], "_result"}, act[k], e);
            end else begin
                cmp({nm[k], "_hold"}, act[k], last[k]);
            end
        end
    end

    task automatic drive(input logic t1, input logic o1, input logic [3:0] opc,
                         input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] e32, input logic [15:0] e16,
                         input logic lk);
        sb_t s;
        @(negedge clk);
        reset = 1'b0;
        t1load = t1;
        o1load = o1;
        op = opc;
        a = aa;
        b = bb;
        glock = lk;
        if (t1 && !lk) begin
            s.due = ucnt + 1; s.v = e32;           sbq[0].push_back(s);
            s.due = ucnt + 1; s.v = {16'd0, e16};  sbq[1].push_back(s);
            s.due = ucnt + 3; s.v = e32;           sbq[2].push_back(s);
            s.due = ucnt + 1; s.v = (opc == 4'd13) ? 32'd0 : e32;
            sbq[3].push_back(s);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset wins over glock and over a simultaneous trigger
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        glock = 1'b1;
        t1load = 1'b1;
        o1load = 1'b1;
        op = 4'd0;
        a = 32'd9;
        b = 32'd9;
    endtask

    initial begin
        nm[0] = "u32"; nm[1] = "u16"; nm[2] = "u3"; nm[3] = "u0";
        for (int k = 0; k < 4; k++) last[k] = 32'd0;

        tv.push_back('{1, 1, 4'd0,  32'd7,        32'd5,        32'd12,       16'd12});
        tv.push_back('{1, 0, 4'd9,  32'd3,        32'd0,        32'hFFFFFFFE, 16'hFFFE});
        tv.push_back('{0, 1, 4'd0,  32'd0,        32'd1,        32'd0,        16'd0});
        tv.push_back('{1, 0, 4'd3,  32'hFFFFFFFF, 32'd0,        32'd0,        16'd0});
        tv.push_back('{1, 0, 4'd4,  32'hFFFFFFFF, 32'd0,        32'd1,        16'd1});
        tv.push_back('{1, 1, 4'd2,  32'h80000000, 32'h80000000, 32'd1,        16'd1});
        tv.push_back('{1, 1, 4'd2,  32'h80000000, 32'h80000001, 32'd0,        16'd0});
        tv.push_back('{1, 1, 4'd6,  32'h00008001, 32'h11,       32'h00020000, 16'h0002});
        tv.push_back('{1, 1, 4'd7,  32'h00008001, 32'h11,       32'd0,        16'hC000});
        tv.push_back('{1, 1, 4'd8,  32'h00008001, 32'h11,       32'd0,        16'h4000});
        tv.push_back('{1, 1, 4'd7,  32'h80000000, 32'h20,       32'h80000000, 16'h0000});
        tv.push_back('{1, 1, 4'd7,  32'h80000000, 32'd4,        32'hF8000000, 16'h0000});
        tv.push_back('{1, 1, 4'd10, 32'h12348000, 32'd0,        32'hFFFF8000, 16'h8000});
        tv.push_back('{1, 1, 4'd11, 32'h00000180, 32'd0,        32'hFFFFFF80, 16'hFF80});
        tv.push_back('{1, 1, 4'd13, 32'h00010003, 32'h00020005, 32'h000B000F, 16'h000F});
        tv.push_back('{1, 1, 4'd12, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 16'h0FF0});
        tv.push_back('{1, 1, 4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 16'hFFF0});
        tv.push_back('{1, 1, 4'd1,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 16'hF000});
        tv.push_back('{1, 1, 4'd14, 32'h12345678, 32'h1,        32'd0,        16'd0});
        tv.push_back('{1, 1, 4'd15, 32'h12345678, 32'h1,        32'd0,        16'd0});
        tv.push_back('{1, 1, 4'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        16'd0});
        tv.push_back('{1, 1, 4'd3,  32'd1,        32'hFFFFFFFF, 32'd1,        16'd1});
        tv.push_back('{1, 1, 4'd4,  32'd1,        32'hFFFFFFFF, 32'd0,        16'd0});
        tv.push_back('{1, 1, 4'd8,  32'h80000000, 32'd31,       32'd1,        16'd0});
        tv.push_back('{1, 1, 4'd6,  32'd1,        32'h3F,       32'h80000000, 16'h8000});

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].t1, tv[i].o1, tv[i].op, tv[i].a, tv[i].b,
                  tv[i].e32, tv[i].e16, 1'b0);
        end
        idle(3);

        drive(1, 1, 4'd0, 32'd1, 32'd1, 32'd2, 16'd2, 0);
        drive(1, 1, 4'd0, 32'd2, 32'd2, 32'd4, 16'd4, 0);
        drive(1, 1, 4'd0, 32'd3, 32'd3, 32'd6, 16'd6, 0);
        idle(4);

        drive(1, 1, 4'd0, 32'd10, 32'd10, 32'd20, 16'd20, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4'd12, 32'hFF, 32'h55, 32'd0, 16'd0, 1);
        end
        idle(3);
        drive(1, 0, 4'd0, 32'd5, 32'd0, 32'd15, 16'd15, 0);
        idle(3);

        drive(1, 1, 4'd0, 32'd100, 32'd1, 32'd101, 16'd101, 0);
        drive(1, 1, 4'd0, 32'd200, 32'd1, 32'd201, 16'd201, 0);
        do_reset();
        idle(4);
        drive(1, 0, 4'd0, 32'd7, 32'd0, 32'd7, 16'd7, 0);
        idle(3);

        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (sbq[k].size() != 0) begin
                n_bad++;
                $display("FAIL %s_drain got %0d pending exp 0", nm[k], sbq[k].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
